// File: rtl/battle_pkg.sv
// battle_pkg -- shared constants for the battle turn sequencer.
//   * FSM state codes (legacy-compatible localparam constants)
//   * battle_control screen codes
//   * USB keycodes for the move / run keys
//   * wild_dmg(): wild pokemon damage table indexed by two random bits
package battle_pkg;

  typedef logic [3:0] battle_state_t;

  localparam battle_state_t ST_IDLE    = 4'd0;
  localparam battle_state_t ST_MENU    = 4'd1;
  localparam battle_state_t ST_P_ANIM  = 4'd2;
  localparam battle_state_t ST_P_APPLY = 4'd3;
  localparam battle_state_t ST_W_ANIM  = 4'd4;
  localparam battle_state_t ST_W_APPLY = 4'd5;
  localparam battle_state_t ST_WIN     = 4'd6;
  localparam battle_state_t ST_LOSE    = 4'd7;
  localparam battle_state_t ST_RUN     = 4'd8;
  localparam battle_state_t ST_DONE    = 4'd9;
  localparam battle_state_t ST_WAIT    = 4'd10;

  localparam logic [2:0] BC_IDLE  = 3'b000;
  localparam logic [2:0] BC_MENU  = 3'b001;
  localparam logic [2:0] BC_P_ATK = 3'b010;
  localparam logic [2:0] BC_W_ATK = 3'b011;
  localparam logic [2:0] BC_WIN   = 3'b100;
  localparam logic [2:0] BC_LOSE  = 3'b101;
  localparam logic [2:0] BC_RUN   = 3'b110;

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_MOVE1 = 8'h1E;
  localparam logic [7:0] KEY_MOVE2 = 8'h1F;
  localparam logic [7:0] KEY_MOVE3 = 8'h20;
  localparam logic [7:0] KEY_RUN   = 8'h29;

  function automatic logic [7:0] wild_dmg(input logic [1:0] sel);
    case (sel)
      2'd0:    return 8'd5;
      2'd1:    return 8'd10;
      2'd2:    return 8'd15;
      default: return 8'd25;
    endcase
  endfunction

endpackage

// File: rtl/battle_lfsr.sv
// battle_lfsr -- free-running 8-bit Galois LFSR (taps 8'hB8), advances every Clk.
// Only the bits the sequencer consumes are brought out.
// Optional: CRIT_HIT_EN adds crit_roll (high when lfsr[7:5]==0).
//   Clk      in   system clock
//   Reset    in   synchronous active-low reset, loads SEED
//   dmg_sel  out  lfsr[1:0], wild damage table index
//   crit_roll out (CRIT_HIT_EN only) critical hit roll
module battle_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       Clk,
  input  logic       Reset,
`ifdef CRIT_HIT_EN
  output logic       crit_roll,
`endif
  output logic [1:0] dmg_sel
);

  logic [7:0] lfsr;

  always_ff @(posedge Clk) begin
    if (!Reset) lfsr <= SEED;
    else        lfsr <= lfsr[0] ? ((lfsr >> 1) ^ 8'hB8) : (lfsr >> 1);
  end

  assign dmg_sel = lfsr[1:0];
`ifdef CRIT_HIT_EN
  assign crit_roll = (lfsr[7:5] == 3'b000);
`endif

endmodule

// File: rtl/battle_turn_ctrl.sv
// battle_turn_ctrl -- turn sequencer for the battle screen.
// Menu -> player attack -> wild attack -> HP update -> faint check, with
// result screens (win / lose / ran away) and a one-shot battle_end back to
// the game FSM. HP changes are committed on entry to the APPLY states so the
// HP bar select strobe and user_hp_wr see the new value during APPLY.
// Optional: CRIT_HIT_EN adds doubled critical damage and the crit output.
//   Clk, Reset      clock, synchronous active-low reset
//   frame_tick      one-Clk pulse per video frame
//   fight_on        battle active; low aborts to IDLE
//   keycode         USB keycode, 0 = none
//   user_hp_in      persisted user HP, loaded at battle start
//   user_hp/wild_hp live HP values
//   user_hp_wr      write-back strobe for user HP
//   hp1/hp2_selbit  user / wild HP bar updating
//   battle_control  screen code
//   poke_faint      high on WIN/LOSE screens
//   crit            (CRIT_HIT_EN only) high during a critical P_ANIM
//   battle_end      one-Clk pulse when the battle finishes
module battle_turn_ctrl
  import battle_pkg::*;
#(
  parameter int         HP_W        = 7,
  parameter int         MAX_HP      = 100,
  parameter int         ANIM_FRAMES = 30,
  parameter int         DMG0        = 10,
  parameter int         DMG1        = 20,
  parameter int         DMG2        = 35,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            frame_tick,
  input  logic            fight_on,
  input  logic [7:0]      keycode,
  input  logic [HP_W-1:0] user_hp_in,
  output logic [HP_W-1:0] user_hp,
  output logic [HP_W-1:0] wild_hp,
  output logic            user_hp_wr,
  output logic            hp1_selbit,
  output logic            hp2_selbit,
  output logic [2:0]      battle_control,
  output logic            poke_faint,
`ifdef CRIT_HIT_EN
  output logic            crit,
`endif
  output logic            battle_end
);

  localparam int CNT_W = $clog2(ANIM_FRAMES + 1);

  battle_state_t   state, state_nxt;
  logic [CNT_W-1:0] fcnt;
  logic            key_armed;
  logic [HP_W-1:0] dmg_q;
  logic [1:0]      dmg_sel;
  logic            key_move, key_acc, anim_done;
  logic [HP_W-1:0] move_dmg;
  logic [HP_W:0]   wild_diff, user_diff;
  logic [HP_W-1:0] wild_sat, user_sat, dmg_new;

`ifdef CRIT_HIT_EN
  logic            crit_roll, crit_q;
  logic [HP_W:0]   dmg_dbl;
`endif

  battle_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .Clk      (Clk),
    .Reset    (Reset),
`ifdef CRIT_HIT_EN
    .crit_roll(crit_roll),
`endif
    .dmg_sel  (dmg_sel)
  );

  assign key_move = (keycode == KEY_MOVE1) || (keycode == KEY_MOVE2) ||
                    (keycode == KEY_MOVE3);
  // Only MENU consumes keys; fight_on gates it so an abort never latches a move.
  assign key_acc   = (state == ST_MENU) && fight_on && key_armed &&
                     (key_move || (keycode == KEY_RUN));
  assign anim_done = frame_tick && (fcnt == CNT_W'(ANIM_FRAMES - 1));

  always_comb begin
    move_dmg = HP_W'(DMG2);
    if (keycode == KEY_MOVE1)      move_dmg = HP_W'(DMG0);
    else if (keycode == KEY_MOVE2) move_dmg = HP_W'(DMG1);
  end

`ifdef CRIT_HIT_EN
  assign dmg_dbl = {move_dmg, 1'b0};
  assign dmg_new = !crit_roll ? move_dmg :
                   (dmg_dbl > (HP_W+1)'(MAX_HP)) ? HP_W'(MAX_HP) : dmg_dbl[HP_W-1:0];
`else
  assign dmg_new = move_dmg;
`endif

  // Saturating subtract: one extra bit catches the borrow.
  assign wild_diff = {1'b0, wild_hp} - {1'b0, dmg_q};
  assign wild_sat  = wild_diff[HP_W] ? '0 : wild_diff[HP_W-1:0];
  assign user_diff = {1'b0, user_hp} - (HP_W+1)'(wild_dmg(dmg_sel));
  assign user_sat  = user_diff[HP_W] ? '0 : user_diff[HP_W-1:0];

  always_comb begin
    state_nxt = state;
    // fight_on low returns to IDLE from everywhere (WAIT's normal exit too).
    if (!fight_on) state_nxt = ST_IDLE;
    else begin
      case (state)
        ST_IDLE:    state_nxt = ST_MENU;
        ST_MENU:    if (key_acc) state_nxt = (keycode == KEY_RUN) ? ST_RUN : ST_P_ANIM;
        ST_P_ANIM:  if (anim_done) state_nxt = ST_P_APPLY;
        ST_P_APPLY: state_nxt = (wild_hp == '0) ? ST_WIN : ST_W_ANIM;
        ST_W_ANIM:  if (anim_done) state_nxt = ST_W_APPLY;
        ST_W_APPLY: state_nxt = (user_hp == '0) ? ST_LOSE : ST_MENU;
        ST_WIN, ST_LOSE, ST_RUN: if (anim_done) state_nxt = ST_DONE;
        ST_DONE:    state_nxt = ST_WAIT;
        ST_WAIT:    state_nxt = ST_WAIT;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= ST_IDLE;
      fcnt      <= '0;
      key_armed <= 1'b0;
      user_hp   <= '0;
      wild_hp   <= '0;
      dmg_q     <= '0;
`ifdef CRIT_HIT_EN
      crit_q    <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state_nxt != state) fcnt <= '0;
      else if (frame_tick)    fcnt <= fcnt + CNT_W'(1);

      // Edge-style acceptance: a held key can fire at most once.
      if (key_acc)                    key_armed <= 1'b0;
      else if (keycode == KEY_NONE)   key_armed <= 1'b1;

      if (state == ST_IDLE && fight_on) begin
        user_hp <= user_hp_in;
        wild_hp <= HP_W'(MAX_HP);
      end
      if (key_acc && key_move) begin
        dmg_q <= dmg_new;
`ifdef CRIT_HIT_EN
        crit_q <= crit_roll;
`endif
      end
      if (state == ST_P_ANIM && state_nxt == ST_P_APPLY) wild_hp <= wild_sat;
      // dmg_sel here is the LFSR value sampled at W_APPLY entry.
      if (state == ST_W_ANIM && state_nxt == ST_W_APPLY) user_hp <= user_sat;
    end
  end

  always_comb begin
    case (state)
      ST_MENU:               battle_control = BC_MENU;
      ST_P_ANIM, ST_P_APPLY: battle_control = BC_P_ATK;
      ST_W_ANIM, ST_W_APPLY: battle_control = BC_W_ATK;
      ST_WIN:                battle_control = BC_WIN;
      ST_LOSE:               battle_control = BC_LOSE;
      ST_RUN:                battle_control = BC_RUN;
      default:               battle_control = BC_IDLE;
    endcase
  end

  assign poke_faint = (state == ST_WIN) || (state == ST_LOSE);
  assign hp2_selbit = (state == ST_P_APPLY);
  assign hp1_selbit = (state == ST_W_APPLY);
  assign user_hp_wr = (state == ST_W_APPLY) && fight_on;
  assign battle_end = (state == ST_DONE) && fight_on;
`ifdef CRIT_HIT_EN
  assign crit = crit_q && (state == ST_P_ANIM);
`endif

endmodule

// File: tb/tb_battle_turn_ctrl.sv
module tb_battle_turn_ctrl;

  localparam int HP_W = 7;

  logic            Clk, Reset, frame_tick, fight_on;
  logic [7:0]      keycode;
  logic [HP_W-1:0] user_hp_in, user_hp, wild_hp;
  logic            user_hp_wr, hp1_selbit, hp2_selbit, poke_faint, battle_end;
  logic [2:0]      battle_control;
`ifdef CRIT_HIT_EN
  logic            crit;
`endif

  battle_turn_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .fight_on(fight_on),
    .keycode(keycode), .user_hp_in(user_hp_in), .user_hp(user_hp), .wild_hp(wild_hp),
    .user_hp_wr(user_hp_wr), .hp1_selbit(hp1_selbit), .hp2_selbit(hp2_selbit),
    .battle_control(battle_control), .poke_faint(poke_faint),
`ifdef CRIT_HIT_EN
    .crit(crit),
`endif
    .battle_end(battle_end)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model (screen-level phases) ----------------
  typedef enum int {P_IDLE, P_MENU, P_PANIM, P_PAPPLY, P_WANIM, P_WAPPLY,
                    P_WIN, P_LOSE, P_RUN, P_DONE, P_WAIT} ph_t;
  ph_t        m_ph;
  int         m_left, m_uhp, m_whp, m_dmg;
  bit         m_armed, m_fo;
  logic [7:0] m_lfsr;
  int         WTBL[4] = '{5, 10, 15, 25};

  task automatic model_step(input bit fo, input logic [7:0] key, input bit tk);
    bit acc;
    acc = (m_ph == P_MENU) && fo && m_armed &&
          (key == 8'h1E || key == 8'h1F || key == 8'h20 || key == 8'h29);
    if (!fo) m_ph = P_IDLE;
    else begin
      case (m_ph)
        P_IDLE: begin m_uhp = int'(user_hp_in); m_whp = 100; m_ph = P_MENU; end
        P_MENU: if (acc) begin
          m_left = 30;
          if (key == 8'h29) m_ph = P_RUN;
          else begin
            m_dmg = (key == 8'h1E) ? 10 : (key == 8'h1F) ? 20 : 35;
            m_ph  = P_PANIM;
          end
        end
        P_PANIM: if (tk) begin
          m_left--;
          if (m_left == 0) begin
            m_whp = (m_whp > m_dmg) ? m_whp - m_dmg : 0;
            m_ph  = P_PAPPLY;
          end
        end
        P_PAPPLY: begin m_ph = (m_whp == 0) ? P_WIN : P_WANIM; m_left = 30; end
        P_WANIM: if (tk) begin
          m_left--;
          if (m_left == 0) begin
            m_uhp = (m_uhp > WTBL[m_lfsr[1:0]]) ? m_uhp - WTBL[m_lfsr[1:0]] : 0;
            m_ph  = P_WAPPLY;
          end
        end
        P_WAPPLY: begin m_ph = (m_uhp == 0) ? P_LOSE : P_MENU; m_left = 30; end
        P_WIN, P_LOSE, P_RUN: if (tk) begin
          m_left--;
          if (m_left == 0) m_ph = P_DONE;
        end
        P_DONE: m_ph = P_WAIT;
        default: ;
      endcase
    end
    if (acc)             m_armed = 1'b0;
    else if (key == 8'h00) m_armed = 1'b1;
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 8'hB8) : (m_lfsr >> 1);
    m_fo = fo;
  endtask

  function automatic logic [21:0] exp_out();
    logic [2:0] bc;
    case (m_ph)
      P_MENU:             bc = 3'd1;
      P_PANIM, P_PAPPLY:  bc = 3'd2;
      P_WANIM, P_WAPPLY:  bc = 3'd3;
      P_WIN:              bc = 3'd4;
      P_LOSE:             bc = 3'd5;
      P_RUN:              bc = 3'd6;
      default:            bc = 3'd0;
    endcase
    return {bc, (m_ph == P_WIN || m_ph == P_LOSE), (m_ph == P_DONE && m_fo),
            (m_ph == P_WAPPLY && m_fo), (m_ph == P_WAPPLY), (m_ph == P_PAPPLY),
            7'(m_uhp), 7'(m_whp)};
  endfunction

  function automatic logic [21:0] dut_out();
    return {battle_control, poke_faint, battle_end, user_hp_wr, hp1_selbit,
            hp2_selbit, user_hp, wild_hp};
  endfunction

  // One clock: compare, drive, step model, advance to next falling edge.
  task automatic cyc(input bit fo, input logic [7:0] key, input bit tk);
    chk("outs", 32'(dut_out()), 32'(exp_out()));
    fight_on = fo; keycode = key; frame_tick = tk;
    model_step(fo, key, tk);
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic do_move(input logic [7:0] key);
    int n;
    cyc(1, key, 0);
    cyc(1, 8'h00, 0);
    n = 0;
    while (!(battle_control == 3'd1 || battle_control >= 3'd4) && n < 300) begin
      cyc(1, 8'h00, 1); n++;
    end
    chk("move_done", 32'(n < 300), 32'd1);
  endtask

  int n, cnt;
  bit rfo;
  logic [7:0] rkey;

  initial begin
    Reset = 1'b0; fight_on = 1'b0; keycode = 8'h00; frame_tick = 1'b0;
    user_hp_in = 7'd50;
    @(posedge Clk); @(posedge Clk); @(negedge Clk);
    chk("rst_bc", 32'(battle_control), 32'd0);
    chk("rst_outs", 32'(dut_out()), 32'd0);
    Reset = 1'b1;
    m_ph = P_IDLE; m_left = 0; m_uhp = 0; m_whp = 0; m_dmg = 0;
    m_armed = 1'b0; m_fo = 1'b0; m_lfsr = 8'hA5;

    // Battle A: load, one attack, held-key single acceptance
    cyc(1, 8'h00, 0);
    chk("menu_bc", 32'(battle_control), 32'd1);
    chk("menu_uhp", 32'(user_hp), 32'd50);
    chk("menu_whp", 32'(wild_hp), 32'd100);
    cyc(1, 8'h1F, 0);
    chk("patk_bc", 32'(battle_control), 32'd2);
    n = 0;
    while (!hp2_selbit && n < 200) begin cyc(1, 8'h00, 1); n++; end
    chk("panim_ticks", 32'(n), 32'd30);
    chk("whp_80", 32'(wild_hp), 32'd80);
    cyc(1, 8'h00, 0);
    chk("watk_bc", 32'(battle_control), 32'd3);
    n = 0;
    while (!(battle_control == 3'd1 || battle_control >= 3'd4) && n < 300) begin
      cyc(1, 8'h00, 1); n++;
    end
    chk("back_menu", 32'(battle_control), 32'd1);
    cnt = 0;
    for (int i = 0; i < 250; i++) begin
      cyc(1, 8'h1E, 1);
      if (hp2_selbit) cnt++;
    end
    chk("hold_once", 32'(cnt), 32'd1);
    cyc(0, 8'h00, 0); cyc(0, 8'h00, 0);
    chk("abort_idle", 32'(battle_control), 32'd0);

    // Battle B: bring wild to 10, finish with saturating move 3
    user_hp_in = 7'd100;
    cyc(1, 8'h00, 0);
    do_move(8'h20); do_move(8'h20); do_move(8'h1F);
    chk("whp_10", 32'(wild_hp), 32'd10);
    cyc(1, 8'h20, 0); cyc(1, 8'h00, 0);
    n = 0;
    while (!hp2_selbit && n < 200) begin cyc(1, 8'h00, 1); n++; end
    chk("whp_sat0", 32'(wild_hp), 32'd0);
    cyc(1, 8'h00, 0);
    chk("win_bc", 32'(battle_control), 32'd4);
    chk("win_faint", 32'(poke_faint), 32'd1);
    n = 0;
    while (!battle_end && n < 200) begin cyc(1, 8'h00, 1); n++; end
    chk("win_ticks", 32'(n), 32'd30);
    cyc(1, 8'h00, 0);
    chk("end_pulse", 32'(battle_end), 32'd0);
    for (int i = 0; i < 10; i++) cyc(1, 8'h00, 1);
    chk("wait_hold", 32'(battle_control), 32'd0);
    cyc(0, 8'h00, 0);

    // Battle C: user 5 HP, any wild hit faints
    user_hp_in = 7'd5;
    cyc(1, 8'h00, 0);
    cyc(1, 8'h1E, 0);
    n = 0;
    while (!hp1_selbit && n < 300) begin cyc(1, 8'h00, 1); n++; end
    chk("uhp_0", 32'(user_hp), 32'd0);
    chk("uhp_wr", 32'(user_hp_wr), 32'd1);
    cyc(1, 8'h00, 0);
    chk("lose_bc", 32'(battle_control), 32'd5);
    n = 0;
    while (!battle_end && n < 200) begin cyc(1, 8'h00, 1); n++; end
    chk("lose_end", 32'(n < 200), 32'd1);
    cyc(0, 8'h00, 0);

    // Battle D: abort mid-animation, then run away
    user_hp_in = 7'd60;
    cyc(1, 8'h00, 0);
    cyc(1, 8'h1F, 0);
    for (int i = 0; i < 5; i++) cyc(1, 8'h00, 1);
    cyc(0, 8'h00, 1);
    chk("abort_bc", 32'(battle_control), 32'd0);
    chk("abort_end", 32'(battle_end), 32'd0);
    chk("abort_wr", 32'(user_hp_wr), 32'd0);
    cyc(0, 8'h00, 0);
    cyc(1, 8'h00, 0);
    chk("reload_whp", 32'(wild_hp), 32'd100);
    cyc(1, 8'h29, 0);
    chk("run_bc", 32'(battle_control), 32'd6);
    chk("run_faint", 32'(poke_faint), 32'd0);
    n = 0;
    while (!battle_end && n < 200) begin cyc(1, 8'h00, 1); n++; end
    chk("run_end", 32'(n), 32'd30);
    cyc(0, 8'h00, 0);

    // Randomized battles against the model
    rfo = 1'b0; rkey = 8'h00;
    for (int i = 0; i < 30000 && n_fail < 20; i++) begin
      if (m_ph == P_IDLE && !rfo) begin
        user_hp_in = 7'($urandom_range(1, 100));
        if ($urandom_range(0, 5) == 0) rfo = 1'b1;
      end else if (m_ph == P_WAIT) begin
        if ($urandom_range(0, 5) == 0) rfo = 1'b0;
      end else if ($urandom_range(0, 1499) == 0) rfo = 1'b0;
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 7))
          3:       rkey = 8'h1E;
          4:       rkey = 8'h1F;
          5:       rkey = 8'h20;
          6:       rkey = 8'h29;
          7:       rkey = 8'($urandom);
          default: rkey = 8'h00;
        endcase
      end
      cyc(rfo, rkey, $urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
